// File: rtl/relu_ctrl_pkg.sv
// rtl/relu_ctrl_pkg.sv - shared state encoding and default latencies for the ReLU stream controller
package relu_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } ctrl_state_t;

    // Also consumed by the lane-bank wrapper so both sides agree on alignment.
    localparam int RD_LAT   = 1;
    localparam int RELU_LAT = 3;

endpackage

// File: rtl/ctrl_delay_line.sv
// rtl/ctrl_delay_line.sv - fixed-depth shift register carrying write-side control alongside the ReLU pipeline
module ctrl_delay_line #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/relu_stream_ctrl.sv
// rtl/relu_stream_ctrl.sv - issues Z reads and latency-aligned A writes for one activation command
module relu_stream_ctrl
    import relu_ctrl_pkg::*;
#(
    parameter int dataWidth   = 32,
    parameter int lanes       = 4,
    parameter int addrWidth   = 10,
    parameter int lenWidth    = 11,
    parameter int rdLatency   = RD_LAT,
    parameter int reluLatency = RELU_LAT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [lenWidth-1:0]  len,
    input  logic [addrWidth-1:0] srcBase,
    input  logic [addrWidth-1:0] dstBase,
    output logic                 busy,
    output logic                 done,
    output logic                 rdEn,
    output logic [addrWidth-1:0] rdAddr,
    output logic                 wrEn,
    output logic [addrWidth-1:0] wrAddr,
    output logic                 wrLast
);

    localparam int L        = rdLatency + reluLatency;
    localparam int DL_WIDTH = 2 + addrWidth;

    // Data width and lane count only describe the datapath this block steers.
    if (dataWidth <= 0 || lanes <= 0) begin : g_bad_datapath_params
    end

    ctrl_state_t          state, next_state;
    logic [lenWidth-1:0]  issue_cnt, last_idx;
    logic [addrWidth-1:0] src_q, dst_q;
    logic                 issue_last, accept;
    logic [DL_WIDTH-1:0]  dl_in, dl_out;
    logic                 out_valid, out_last;
    logic [addrWidth-1:0] out_offset;

    assign accept     = (state == IDLE) && start && (len != '0);
    assign issue_last = (issue_cnt == last_idx);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        rdEn       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (len == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                busy = 1'b1;
                rdEn = 1'b1;
                if (issue_last) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (out_valid && out_last) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // The counter parks on the final index so both addresses hold between commands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issue_cnt <= '0;
            last_idx  <= '0;
            src_q     <= '0;
            dst_q     <= '0;
        end else if (accept) begin
            issue_cnt <= '0;
            last_idx  <= len - lenWidth'(1);
            src_q     <= srcBase;
            dst_q     <= dstBase;
        end else if (state == ISSUE && !issue_last) begin
            issue_cnt <= issue_cnt + lenWidth'(1);
        end
    end

    assign rdAddr = src_q + addrWidth'(issue_cnt);
    assign dl_in  = {rdEn, rdEn && issue_last, addrWidth'(issue_cnt)};

    ctrl_delay_line #(
        .DEPTH (L),
        .WIDTH (DL_WIDTH)
    ) u_delay (
        .clk   (clk),
        .rst_n (rst),
        .din   (dl_in),
        .dout  (dl_out)
    );

    assign {out_valid, out_last, out_offset} = dl_out;

    assign wrEn   = out_valid;
    assign wrLast = out_valid && out_last;
    assign wrAddr = dst_q + out_offset;

endmodule

// File: tb/tb_relu_stream_ctrl.sv
// tb/tb_relu_stream_ctrl.sv - scoreboard bench for relu_stream_ctrl
module tb_relu_stream_ctrl;

    localparam int LAT = 4;

    typedef struct {
        int         cyc;
        logic [9:0] addr;
        logic       last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [10:0] len;
    logic [9:0]  srcBase, dstBase;
    logic        busy, done, rdEn, wrEn, wrLast;
    logic [9:0]  rdAddr, wrAddr;

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   busy_lo = 0;
    int   busy_hi = -1;
    bit   zero_phase = 1'b0;
    exp_t rd_exp[$];
    exp_t wr_exp[$];
    int   done_exp[$];
    exp_t e_rd, e_wr;
    bit   due_rd, due_wr, due_dn;

    relu_stream_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .len     (len),
        .srcBase (srcBase),
        .dstBase (dstBase),
        .busy    (busy),
        .done    (done),
        .rdEn    (rdEn),
        .rdAddr  (rdAddr),
        .wrEn    (wrEn),
        .wrAddr  (wrAddr),
        .wrLast  (wrLast)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=0x%0h want=0x%0h", tag, cyc, got, want);
        end
    endtask

    always @(negedge clk) begin
        due_rd = rd_exp.size() != 0 && rd_exp[0].cyc == cyc;
        chk("rd_en", rdEn, due_rd);
        if (due_rd) begin
            e_rd = rd_exp.pop_front();
            if (rdEn) chk("rd_addr", rdAddr, e_rd.addr);
        end
        due_wr = wr_exp.size() != 0 && wr_exp[0].cyc == cyc;
        chk("wr_en", wrEn, due_wr);
        if (due_wr) begin
            e_wr = wr_exp.pop_front();
            if (wrEn) chk("wr_addr", wrAddr, e_wr.addr);
            chk("wr_last", wrLast, e_wr.last);
        end else begin
            chk("wr_last_idle", wrLast, 0);
        end
        due_dn = done_exp.size() != 0 && done_exp[0] == cyc;
        chk("done", done, due_dn);
        if (due_dn) void'(done_exp.pop_front());
        chk("busy", busy, cyc >= busy_lo && cyc <= busy_hi);
        if (zero_phase) begin
            chk("idle_rd_addr", rdAddr, 0);
            chk("idle_wr_addr", wrAddr, 0);
        end
    end

    // Called just after a falling edge; start is high for exactly one cycle.
    task automatic issue(input int n, input logic [9:0] src, input logic [9:0] dst,
                         input bit accepted, output int t);
        exp_t e;
        start   = 1'b1;
        len     = 11'(n);
        srcBase = src;
        dstBase = dst;
        t       = cyc;
        if (accepted) begin
            if (n == 0) begin
                done_exp.push_back(t + 1);
            end else begin
                for (int k = 0; k < n; k++) begin
                    e.cyc = t + 1 + k;       e.addr = src + 10'(k); e.last = 1'b0;
                    rd_exp.push_back(e);
                    e.cyc = t + 1 + LAT + k; e.addr = dst + 10'(k); e.last = (k == n - 1);
                    wr_exp.push_back(e);
                end
                done_exp.push_back(t + n + LAT + 1);
                busy_lo = t + 1;
                busy_hi = t + n + LAT;
            end
        end
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while ((rd_exp.size() + wr_exp.size() + done_exp.size()) != 0 && guard < 200) begin
            @(negedge clk); #1;
            guard++;
        end
        chk("drain_timeout", guard < 200, 1);
        @(negedge clk); #1;
    endtask

    initial begin
        int t;
        rst = 1'b0; start = 1'b0; len = '0; srcBase = '0; dstBase = '0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_rd_addr", rdAddr, 0);
        chk("rst_wr_addr", wrAddr, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        zero_phase = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        zero_phase = 1'b0;

        issue(5, 10'h010, 10'h200, 1'b1, t);
        wait_idle();

        issue(0, 10'h123, 10'h321, 1'b1, t);
        wait_idle();

        issue(4, 10'h3FE, 10'h3FF, 1'b1, t);
        wait_idle();

        issue(5, 10'h040, 10'h080, 1'b1, t);
        repeat (2) begin @(negedge clk); #1; end
        issue(9, 10'h300, 10'h100, 1'b0, t);
        wait_idle();

        issue(1, 10'h055, 10'h066, 1'b1, t);
        wait_idle();

        // Async reset lands mid-cycle, between clock edges.
        issue(8, 10'h020, 10'h120, 1'b1, t);
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b0;
        rd_exp.delete(); wr_exp.delete(); done_exp.delete();
        busy_hi = -1;
        #1;
        chk("async_rd_en", rdEn, 0);
        chk("async_rd_addr", rdAddr, 0);
        chk("async_busy", busy, 0);
        chk("async_wr_en", wrEn, 0);
        chk("async_wr_addr", wrAddr, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        issue(2, 10'h0A0, 10'h0B0, 1'b1, t);
        wait_idle();

        for (int r = 0; r < 4; r++) begin
            issue($urandom_range(1, 12), 10'($urandom), 10'($urandom), 1'b1, t);
            wait_idle();
        end

        chk("rd_q_empty", rd_exp.size(), 0);
        chk("wr_q_empty", wr_exp.size(), 0);
        chk("done_q_empty", done_exp.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog");
    end

endmodule
